// File: rtl/exu_divider_pkg.sv
// Shared constants, op/state encodings and request record for the RV32M
// radix-2 restoring divider.
package exu_divider_pkg;

  localparam int DIV_DW    = 32;
  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_CALC  = 2'b10,
    S_END   = 2'b11
  } div_state_e;

  typedef struct packed {
    div_op_e           op;
    logic [DIV_DW-1:0] dividend;
    logic [DIV_DW-1:0] divisor;
    logic [4:0]        waddr;
  } div_req_t;

  function automatic logic op_signed(div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_rem(div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/exu_divider_div_iter.sv
// One combinational radix-2 restoring step: shift in the next dividend bit,
// trial-subtract the divisor, emit one quotient bit.
module div_iter #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] r_i,
  input  logic [DW-1:0] q_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] r_o,
  output logic [DW-1:0] q_o
);
  logic [DW:0]   t;
  logic [DW-1:0] diff;
  logic          ge;

  assign t    = {r_i, q_i[DW-1]};
  assign ge   = t >= {1'b0, d_i};
  // When ge holds the true difference is below d_i, so the low DW bits are exact.
  assign diff = t[DW-1:0] - d_i;
  assign r_o  = ge ? diff : t[DW-1:0];
  assign q_o  = {q_i[DW-2:0], ge};
endmodule

// File: rtl/exu_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit feeding the muldiv write-back port.
// Optional: define DIV_EARLY_OUT_EN to skip iterations when |dividend| < |divisor|.
module exu_divider
  import exu_divider_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  input  logic [4:0]    waddr_i,
  input  logic          flush_i,
  output logic          busy_o,
  output logic          ready_o,
  output logic          reg_we_o,
  output logic [4:0]    reg_waddr_o,
  output logic [DW-1:0] reg_wdata_o
);
  div_state_e           state_q, state_nxt;
  div_req_t             req_q;
  logic [DW-1:0]        r_q, q_q, d_q, r_nxt, q_nxt;
  logic [DW-1:0]        abs_a, abs_b, res;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic                 q_neg_q, r_neg_q;
  logic                 is_signed, div_zero, ovf, early;
  logic                 ready_q, we_q;
  logic [4:0]           waddr_q;
  logic [DW-1:0]        wdata_q;

  assign is_signed = op_signed(req_q.op);
  assign abs_a     = (is_signed && req_q.dividend[DW-1]) ? -req_q.dividend : req_q.dividend;
  assign abs_b     = (is_signed && req_q.divisor[DW-1])  ? -req_q.divisor  : req_q.divisor;
  assign div_zero  = (req_q.divisor == '0);
  assign ovf       = is_signed && (req_q.dividend == {1'b1, {(DW-1){1'b0}}}) &&
                     (req_q.divisor == '1);
`ifdef DIV_EARLY_OUT_EN
  assign early     = !div_zero && (abs_a < abs_b);
`else
  assign early     = 1'b0;
`endif

  div_iter #(.DW(DW)) u_iter (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_nxt),
    .q_o (q_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:  if (req_i && !flush_i) state_nxt = S_START;
      S_START: begin
        if (flush_i)                        state_nxt = S_IDLE;
        else if (div_zero || ovf || early)  state_nxt = S_END;
        else                                state_nxt = S_CALC;
      end
      S_CALC: begin
        if (flush_i)                                       state_nxt = S_IDLE;
        else if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1))       state_nxt = S_END;
      end
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Special cases preload Q/R so the same sign fix-up in END covers every path.
  assign res = op_rem(req_q.op) ? (r_neg_q ? -r_q : r_q) : (q_neg_q ? -q_q : q_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      unique case (state_q)
        S_IDLE: if (req_i && !flush_i)
          req_q <= '{op: div_op_e'(op_i), dividend: dividend_i,
                     divisor: divisor_i, waddr: waddr_i};
        S_START: begin
          d_q     <= abs_b;
          cnt_q   <= '0;
          q_neg_q <= is_signed && !div_zero && (req_q.dividend[DW-1] ^ req_q.divisor[DW-1]);
          r_neg_q <= is_signed && req_q.dividend[DW-1];
          if (div_zero) begin
            q_q <= '1;
            r_q <= abs_a;
          end else if (ovf) begin
            q_q <= {1'b1, {(DW-1){1'b0}}};
            r_q <= '0;
          end else if (early) begin
            q_q <= '0;
            r_q <= abs_a;
          end else begin
            q_q <= abs_a;
            r_q <= '0;
          end
        end
        S_CALC: begin
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + 1'b1;
        end
        S_END: if (!flush_i) begin
          ready_q <= 1'b1;
          we_q    <= 1'b1;
          waddr_q <= req_q.waddr;
          wdata_q <= res;
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q == S_START) || (state_q == S_CALC);
  assign ready_o     = ready_q;
  assign reg_we_o    = we_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;
endmodule

// File: tb/tb_exu_divider.sv
// Scoreboard bench for exu_divider: driver pushes model results, monitor pops on ready_o.
module tb_exu_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] dividend_i = '0, divisor_i = '0;
  logic [4:0]  waddr_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, ready_o, reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  exu_divider dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .waddr_i(waddr_i),
    .flush_i(flush_i), .busy_o(busy_o), .ready_o(ready_o), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  waddr;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy_o) busy_cnt <= busy_cnt + 1;

  // Reference: RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_res(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    int signed as, bs;
    logic ovf;
    as  = $signed(a);
    bs  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(as / bs);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(as % bs);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic sgn;
    logic [31:0] ma, mb;
    sgn = !op[0];
    if (b == 0) return 2;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`else
    if (ma < mb) return 34;
`endif
    return 34;
  endfunction

  // Monitor: every negedge out of reset, check the write-back port.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      checks++;
      if (reg_we_o !== ready_o) begin
        failures++;
        $display("FAIL we_vs_ready: reg_we_o=%b ready_o=%b", reg_we_o, ready_o);
      end
      if (ready_o) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL spurious_ready: wdata=%h waddr=%0d with nothing expected",
                   reg_wdata_o, reg_waddr_o);
        end else begin
          e = sb.pop_front();
          checks += 2;
          if (reg_wdata_o !== e.wdata || reg_waddr_o !== e.waddr) begin
            failures++;
            $display("FAIL result: got wdata=%h waddr=%0d, want wdata=%h waddr=%0d",
                     reg_wdata_o, reg_waddr_o, e.wdata, e.waddr);
          end
          if (cyc - e.acc != e.lat) begin
            failures++;
            $display("FAIL latency: got %0d cycles, want %0d", cyc - e.acc, e.lat);
          end
        end
      end else begin
        checks++;
        if (reg_wdata_o !== '0 || reg_waddr_o !== '0) begin
          failures++;
          $display("FAIL idle_zero: wdata=%h waddr=%0d want 0", reg_wdata_o, reg_waddr_o);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit chk);
    exp_t e;
    req_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; waddr_i = rd;
    if (chk) begin
      e.wdata = ref_res(op, a, b);
      e.waddr = rd;
      e.acc   = cyc + 1;
      e.lat   = ref_lat(op, a, b);
      sb.push_back(e);
    end
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles", sb.size(), n);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    #1;
    check1("reset_outs", {busy_o, ready_o, reg_we_o, reg_waddr_o},  32'h0);
    check1("reset_wdata", reg_wdata_o, 32'h0);
    #20 rst_n = 1'b1;
    @(negedge clk);

    // Normal DIVU with busy-length check
    busy_cnt = 0;
    issue(2'b01, 32'd100, 32'd7, 5'd5, 1'b1);
    wait_done();
    check1("busy_len_normal", busy_cnt, 32'd33);
    issue(2'b11, 32'd100, 32'd7, 5'd5, 1'b1);  wait_done();
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 1'b1);  wait_done();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 1'b1);  wait_done();
    issue(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3, 1'b1);  wait_done();
    busy_cnt = 0;
    issue(2'b01, 32'd123, 32'd0, 5'd4, 1'b1);  wait_done();
    check1("busy_len_special", busy_cnt, 32'd1);
    issue(2'b11, 32'd123, 32'd0, 5'd6, 1'b1);  wait_done();
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1);  wait_done();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1);  wait_done();
    issue(2'b01, 32'd3, 32'd10, 5'd8, 1'b1);  wait_done();
    issue(2'b11, 32'd3, 32'd10, 5'd9, 1'b1);  wait_done();
    issue(2'b10, 32'hFFFF_FFF0, 32'd0, 5'd10, 1'b1);  wait_done();

    // Flush on the 10th CALC cycle, then an immediate fresh request
    issue(2'b01, 32'd1000, 32'd3, 5'd11, 1'b0);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check1("busy_after_flush", {31'b0, busy_o}, 32'h0);
    issue(2'b00, 32'hFFFF_FC18, 32'd7, 5'd12, 1'b1);  wait_done();

    // Flush together with a request in IDLE: request must be dropped
    flush_i = 1'b1;
    issue(2'b01, 32'd50, 32'd5, 5'd13, 1'b0);
    flush_i = 1'b0;
    check1("flush_wins_idle", {31'b0, busy_o}, 32'h0);
    repeat (40) @(negedge clk);

    // req_i pulsed mid-CALC with different operands is ignored
    issue(2'b11, 32'd9999, 32'd97, 5'd14, 1'b1);
    repeat (5) @(negedge clk);
    req_i = 1'b1; op_i = 2'b00; dividend_i = 32'd1; divisor_i = 32'd1; waddr_i = 5'd31;
    @(negedge clk);
    req_i = 1'b0;
    wait_done();

    // Async reset mid-CALC
    issue(2'b01, 32'd77777, 32'd5, 5'd15, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("rst_mid_outs", {busy_o, ready_o, reg_we_o, reg_waddr_o}, 32'h0);
    check1("rst_mid_wdata", reg_wdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check1("idle_after_rst", {31'b0, busy_o}, 32'h0);
    issue(2'b01, 32'd77777, 32'd5, 5'd15, 1'b1);  wait_done();

    // Randomized mix: random, zero divisor, overflow, small operands
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 60); end
        3: b = $urandom_range(1, 16) | ({32{b[31]}} << 4);
        default: ;
      endcase
      issue(op, a, b, 5'($urandom_range(0, 31)), 1'b1);
      wait_done();
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
